fifo_rr_arbiter: RTL and testbench

Drains NUM_CH virtual-channel input FIFOs into one shared output FIFO, one word per cycle, granting channels round-robin. It sits between the per-channel FIFOs and the downstream FIFO, and applies flow control using the downstream almost_full/full flags. It reports idle / pause / error status in the same style as the flow-control FSM.

---
 rtl/fifo_arb_pkg.sv | 43 ++++
 rtl/fifo_rr_arbiter_rr_grant.sv | 28 ++
 rtl/fifo_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and grant search for the channel-drain arbiter.
package fifo_arb_pkg;

    localparam int STATE_W = 5;

    localparam logic [STATE_W-1:0] ST_INIT   = 5'b00001;
    localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00010;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b00100;
    localparam logic [STATE_W-1:0] ST_PAUSE  = 5'b01000;
    localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

    localparam int MAX_CH   = 8;
    localparam int MAX_CH_W = 3;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } grant_t;

    // First set request scanning cyclically upward from ptr over n channels.
    function automatic grant_t next_grant(
        input logic [MAX_CH-1:0]   req,
        input logic [MAX_CH_W-1:0] ptr,
        input int                  n
    );
        grant_t              g;
        int                  c;
        logic [MAX_CH_W-1:0] c3;
        g = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n) begin
                c  = (int'(ptr) + k) % n;
                c3 = MAX_CH_W'(c);
                if (req[c3]) begin
                    g.found = 1'b1;
                    g.idx   = c3;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// Cyclic priority finder: first requesting channel at or after ptr_i.
module rr_grant
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic              found_o,
    output logic [CH_W-1:0]   idx_o
);

    logic [MAX_CH-1:0]   req_w;
    logic [MAX_CH_W-1:0] ptr_w;
    grant_t              g;

    always_comb begin
        req_w              = '0;
        req_w[NUM_CH-1:0]  = req_i;
        ptr_w              = '0;
        ptr_w[CH_W-1:0]    = ptr_i;
        g                  = next_grant(req_w, ptr_w, NUM_CH);
        found_o            = g.found;
        idx_o              = g.idx[CH_W-1:0];
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains NUM_CH channel FIFOs into one downstream FIFO, two-cycle pop-to-push.
// Define ARB_STRICT_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iniciar,
    input  logic [NUM_CH-1:0]        in_empty,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_pop,
    input  logic                     out_almost_full,
    input  logic                     out_full,
    output logic                     out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     idle,
    output logic                     pausa,
    output logic                     error_full
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               v1_q;
    logic [CH_W-1:0]    g1_q;
    logic               push_q;
    logic [DATA_W-1:0]  data_q;
    logic [CH_W-1:0]    ch_q;

    logic [NUM_CH-1:0]  req;
    logic               any_req;
    logic               gnt_found;
    logic [CH_W-1:0]    gnt_idx;
    logic               gnt;
    logic [DATA_W-1:0]  ch_data [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    assign req     = ~in_empty;
    assign any_req = |req;

`ifdef ARB_STRICT_PRIORITY_EN
    grant_t             sg;
    logic [MAX_CH-1:0]  sreq;

    always_comb begin
        sreq             = '0;
        sreq[NUM_CH-1:0] = req;
        sg               = next_grant(sreq, '0, NUM_CH);
        gnt_found        = sg.found;
        gnt_idx          = sg.idx[CH_W-1:0];
    end
`else
    logic [CH_W-1:0] ptr_q, ptr_d;

    rr_grant #(.NUM_CH(NUM_CH)) u_grant (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (gnt_found),
        .idx_o   (gnt_idx)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (gnt) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt = (state_q == ST_ACTIVE) && !out_almost_full
              && !out_full && gnt_found;

    always_comb begin
        in_pop = '0;
        if (gnt && !rst) begin
            in_pop[gnt_idx] = 1'b1;
        end
    end

    // full beats almost_full, which beats empty
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:   if (iniciar) state_d = ST_IDLE;
            ST_IDLE:   if (any_req) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (out_full)             state_d = ST_ERROR;
                else if (out_almost_full) state_d = ST_PAUSE;
                else if (!any_req)        state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (out_full)              state_d = ST_ERROR;
                else if (!out_almost_full) state_d = any_req ? ST_ACTIVE : ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            v1_q    <= 1'b0;
            g1_q    <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_ERROR) begin
                v1_q   <= 1'b0;
                push_q <= 1'b0;
            end else begin
                v1_q   <= gnt;
                push_q <= v1_q;
            end
            if (gnt) begin
                g1_q <= gnt_idx;
            end
            if (v1_q) begin
                data_q <= ch_data[g1_q];
                ch_q   <= g1_q;
            end
        end
    end

    // a push colliding with full is dropped
    assign out_push   = push_q && !out_full;
    assign out_data   = data_q;
    assign out_ch     = ch_q;
    assign idle       = (state_q == ST_IDLE);
    assign pausa      = (state_q == ST_PAUSE);
    assign error_full = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomized and directed bench for fifo_rr_arbiter against a queue-based model.
// Honours ARB_STRICT_PRIORITY_EN to select the expected arbitration policy.
module tb_fifo_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iniciar = 1'b0;
    logic [3:0]   in_empty = 4'hF;
    logic [31:0]  in_data = '0;
    logic [3:0]   in_pop;
    logic         afull = 1'b0;
    logic         full = 1'b0;
    logic         out_push;
    logic [7:0]   out_data;
    logic [1:0]   out_ch;
    logic         idle, pausa, error_full;

    fifo_rr_arbiter #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar),
        .in_empty(in_empty), .in_data(in_data), .in_pop(in_pop),
        .out_almost_full(afull), .out_full(full),
        .out_push(out_push), .out_data(out_data), .out_ch(out_ch),
        .idle(idle), .pausa(pausa), .error_full(error_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] d;
        int         ch;
    } pend_t;

    logic [7:0] q [4][$];
    logic [7:0] rd_data [4];
    pend_t      pend [$];
    int         pop_log [$];
    logic [7:0] push_log [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ms = 0;
    int mptr = 0;
    bit armed = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void sync_env();
        for (int i = 0; i < N; i++) begin
            in_empty[i]       = (q[i].size() == 0);
            in_data[i*8 +: 8] = rd_data[i];
        end
    endfunction

    function automatic int any_ne();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
        return 0;
    endfunction

    // Compare at negedge, advance model, then let the channel FIFOs react.
    task automatic tick();
        int         eg;
        int         st;
        int         nms;
        logic [3:0] ep;
        logic [3:0] dpop;
        bit         ep_push;
        sync_env();
        @(negedge clk);
        eg = -1;
        st = 0;
`ifndef ARB_STRICT_PRIORITY_EN
        st = mptr;
`endif
        if (!rst && ms == 2 && !afull && !full) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (q[(st + k) % N].size() > 0) eg = (st + k) % N;
            end
        end
        ep = (eg >= 0) ? 4'(1 << eg) : 4'h0;
        ep_push = (pend.size() > 0 && pend[0].due == cyc && !full);
        if (armed) begin
            chk("in_pop", in_pop, ep);
            chk("out_push", out_push, ep_push);
            if (ep_push) begin
                chk("out_data", out_data, pend[0].d);
                chk("out_ch", out_ch, pend[0].ch);
            end
            chk("idle", idle, ms == 1);
            chk("pausa", pausa, ms == 3);
            chk("error_full", error_full, ms == 4);
        end
        dpop = in_pop;
        for (int i = 0; i < N; i++) if (dpop[i]) pop_log.push_back(i);
        if (out_push === 1'b1) push_log.push_back(out_data);
        if (rst) begin
            ms = 0;
            mptr = 0;
            pend.delete();
        end else begin
            nms = ms;
            case (ms)
                0: if (iniciar) nms = 1;
                1: if (any_ne() != 0) nms = 2;
                2: if (full) nms = 4;
                   else if (afull) nms = 3;
                   else if (any_ne() == 0) nms = 1;
                3: if (full) nms = 4;
                   else if (!afull) nms = (any_ne() != 0) ? 2 : 1;
                default: nms = ms;
            endcase
            if (eg >= 0) begin
                pend.push_back('{due: cyc + 2, d: q[eg][0], ch: eg});
                mptr = (eg + 1) % N;
            end
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if (nms == 4) pend.delete();
            ms = nms;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (dpop[i] && !rst && q[i].size() > 0) rd_data[i] = q[i].pop_front();
        end
        sync_env();
        armed = 1;
    endtask

    task automatic fill(int n, logic [7:0] base);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < n; k++) q[i].push_back(base + 8'(i * 16 + k));
    endtask

    task automatic wait_pops(int n);
        for (int k = 0; k < 40 && pop_log.size() < n; k++) tick();
        chk("pop_wait", 32'(pop_log.size() >= n), 1);
    endtask

    int pb, pp, err_cnt;
    logic [7:0] exp_t1 [8];

    initial begin
        for (int i = 0; i < N; i++) rd_data[i] = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_push", out_push, 0);
        chk("rst_status", {idle, pausa, error_full}, 0);
        chk("rst_data", {out_data, out_ch}, 0);

        // 1: two words per channel drain in rotation
        fill(2, 8'h00);
        iniciar = 1;
        pop_log.delete();
        push_log.delete();
        for (int k = 0; k < 16; k++) tick();
        iniciar = 0;
        chk("t1_npop", pop_log.size(), 8);
        chk("t1_npush", push_log.size(), 8);
        exp_t1 = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
        for (int k = 0; k < 8 && k < pop_log.size(); k++) chk("t1_pop", pop_log[k], k % 4);
        for (int k = 0; k < 8 && k < push_log.size(); k++) chk("t1_data", push_log[k], exp_t1[k]);
        chk("t1_idle", idle, 1);

        // 2: single channel
        pop_log.delete();
        push_log.delete();
        for (int k = 0; k < 3; k++) q[2].push_back(8'hA0 + 8'(k));
        for (int k = 0; k < 10; k++) tick();
        chk("t2_npop", pop_log.size(), 3);
        for (int k = 0; k < 3 && k < pop_log.size(); k++) chk("t2_pop", pop_log[k], 2);
        chk("t2_ptr", mptr, 3);
        chk("t2_npush", push_log.size(), 3);

        // 3: almost_full after second pop
        pop_log.delete();
        fill(6, 8'h40);
        wait_pops(2);
        afull = 1;
        pb = push_log.size();
        tick();
        chk("t3_nopop", pop_log.size(), 2);
        chk("t3_pausa", pausa, 1);
        for (int k = 0; k < 5; k++) tick();
        chk("t3_inflight", push_log.size() - pb, 2);
        chk("t3_hold", pop_log.size(), 2);
        afull = 0;
        wait_pops(3);
        if (pop_log.size() >= 3) chk("t3_resume", pop_log[2], (pop_log[1] + 1) % N);
        for (int k = 0; k < 40; k++) tick();

        // 4: full pulse while streaming
        pop_log.delete();
        fill(6, 8'h80);
        wait_pops(3);
        full = 1;
        tick();
        full = 0;
        chk("t4_err", error_full, 1);
        pb = pop_log.size();
        pp = push_log.size();
        for (int k = 0; k < 20; k++) tick();
        chk("t4_nopop", pop_log.size() - pb, 0);
        chk("t4_nopush", push_log.size() - pp, 0);
        chk("t4_sticky", error_full, 1);

        // 5: reset mid-burst
        rst = 1;
        tick();
        rst = 0;
        iniciar = 1;
        pop_log.delete();
        wait_pops(3);
        iniciar = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("t5_push", out_push, 0);
        chk("t5_status", {idle, pausa, error_full}, 0);
        pb = pop_log.size();
        for (int k = 0; k < 5; k++) tick();
        chk("t5_nopop", pop_log.size() - pb, 0);
        iniciar = 1;
        for (int k = 0; k < 60; k++) tick();
        iniciar = 0;

`ifdef ARB_STRICT_PRIORITY_EN
        // 6: fixed priority
        pop_log.delete();
        for (int k = 0; k < 5; k++) begin
            q[0].push_back(8'hC0 + 8'(k));
            q[3].push_back(8'hD0 + 8'(k));
        end
        wait_pops(6);
        for (int k = 0; k < 5 && k < pop_log.size(); k++) chk("t6_ch0", pop_log[k], 0);
        if (pop_log.size() >= 6) chk("t6_ch3", pop_log[5], 3);
        for (int k = 0; k < 20; k++) tick();
`endif

        // random phase
        err_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0 && q[i].size() < 8)
                    q[i].push_back(8'($urandom));
            if ($urandom_range(0, 9) == 0) afull = ~afull;
            full = ($urandom_range(0, 299) == 0);
            iniciar = $urandom_range(0, 1);
            rst = (err_cnt > 6) || ($urandom_range(0, 499) == 0);
            err_cnt = (ms == 4) ? err_cnt + 1 : 0;
            tick();
        end
        rst = 0;
        full = 0;
        afull = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
